// File: rtl/even_pipe.sv
// even_pipe: even-side execution pipe of the dual-issue SPU core.
//
// Each clock, the instruction presented by issue/register-fetch is executed
// combinationally. The result and its writeback metadata are packed into a
// 143-bit word, and that word shifts through seven stage registers. Every
// stage is visible so forwarding and hazard logic can inspect it. Stage 7
// drives the register-file write port.
//
// Packed word layout. Field names give bit positions counted from the MSB;
// the bracketed ranges give the vector slices actually used.
//   result   [142:15]  128 bits
//   reg_dst  [14:8]    7 bits
//   reg_wr   [7]       1 bit
//   latency  [6:3]     4 bits
//   unit_id  [2:0]     3 bits
//
// Ports
//   clk, rst                 clock; reset is asynchronous and active-low
//   full_isntr               raw instruction word, trace only
//   instr_id                 decoded opcode id, forwarded to FX1_ALU
//   reg_dst, reg_wr          destination address and write flag
//   unit_id, latency         unit select (000 = FX1) and latency tag
//   ra/rb/rc_data            128-bit source operands
//   imme7/10/16/18           immediates
//   packed_result_Nstage     contents of stage N (N = 1..7)
//   WB_reg_write_*           register-file write port, sliced from stage 7
//
// Handshake: none. There is no valid, ready or stall. Every clock edge
// accepts the current inputs into stage 1 and advances every stage by one.

module FX1_ALU (
  input  logic [6:0]   instr_id,
  input  logic [127:0] ra,
  input  logic [127:0] rb,
  input  logic [127:0] rc,
  input  logic [7:0]   imme7,
  input  logic [9:0]   imme10,
  input  logic [15:0]  imme16,
  input  logic [17:0]  imme18,
  output logic [127:0] result
);
  // Stand-in for the fixed-point unit: a 128-bit add with the carry dropped.
  assign result = ra + rb;

  // These operands are carried on the interface but are not used by this stand-in.
  logic unused_ok;
  assign unused_ok = ^{instr_id, rc, imme7, imme10, imme16, imme18};
endmodule

module even_pipe (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  full_isntr,
  input  logic [6:0]   instr_id,
  input  logic [6:0]   reg_dst,
  input  logic [2:0]   unit_id,
  input  logic [3:0]   latency,
  input  logic         reg_wr,
  input  logic [127:0] ra_data,
  input  logic [127:0] rb_data,
  input  logic [127:0] rc_data,
  input  logic [7:0]   imme7,
  input  logic [9:0]   imme10,
  input  logic [15:0]  imme16,
  input  logic [17:0]  imme18,
  output logic [142:0] packed_result_1stage,
  output logic [142:0] packed_result_2stage,
  output logic [142:0] packed_result_3stage,
  output logic [142:0] packed_result_4stage,
  output logic [142:0] packed_result_5stage,
  output logic [142:0] packed_result_6stage,
  output logic [142:0] packed_result_7stage,
  output logic [6:0]   WB_reg_write_addr,
  output logic [127:0] WB_reg_write_data,
  output logic         WB_reg_write_en
);
  localparam logic [2:0] UNIT_FX1 = 3'b000;

  logic [127:0] fx1_result;
  logic [127:0] exec_result;
  logic [142:0] stage_d;
  logic [142:0] stage_q [1:7];

  FX1_ALU u_fx1 (
    .instr_id (instr_id),
    .ra       (ra_data),
    .rb       (rb_data),
    .rc       (rc_data),
    .imme7    (imme7),
    .imme10   (imme10),
    .imme16   (imme16),
    .imme18   (imme18),
    .result   (fx1_result)
  );

  // Only FX1 is implemented on this pipe. Any other unit code produces a zero
  // result, but its metadata still travels the pipe unchanged.
  assign exec_result = (unit_id == UNIT_FX1) ? fx1_result : '0;
  assign stage_d     = {exec_result, reg_dst, reg_wr, latency, unit_id};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 1; k <= 7; k++) stage_q[k] <= '0;
    end else begin
      stage_q[1] <= stage_d;
      for (int k = 2; k <= 7; k++) stage_q[k] <= stage_q[k-1];
    end
  end

  assign packed_result_1stage = stage_q[1];
  assign packed_result_2stage = stage_q[2];
  assign packed_result_3stage = stage_q[3];
  assign packed_result_4stage = stage_q[4];
  assign packed_result_5stage = stage_q[5];
  assign packed_result_6stage = stage_q[6];
  assign packed_result_7stage = stage_q[7];

  assign WB_reg_write_data = stage_q[7][142:15];
  assign WB_reg_write_addr = stage_q[7][14:8];
  assign WB_reg_write_en   = stage_q[7][7];

  // The raw instruction word is carried for tracing only.
  logic unused_isntr;
  assign unused_isntr = ^full_isntr;
endmodule

// File: tb/tb_even_pipe.sv
module tb_even_pipe;
  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [31:0]  full_isntr = '0;
  logic [6:0]   instr_id = '0;
  logic [6:0]   reg_dst = '0;
  logic [2:0]   unit_id = '0;
  logic [3:0]   latency = '0;
  logic         reg_wr = 1'b0;
  logic [127:0] ra_data = '0;
  logic [127:0] rb_data = '0;
  logic [127:0] rc_data = '0;
  logic [7:0]   imme7 = '0;
  logic [9:0]   imme10 = '0;
  logic [15:0]  imme16 = '0;
  logic [17:0]  imme18 = '0;
  logic [142:0] ps [1:7];
  logic [6:0]   wb_addr;
  logic [127:0] wb_data;
  logic         wb_en;

  even_pipe dut (
    .clk(clk), .rst(rst), .full_isntr(full_isntr), .instr_id(instr_id),
    .reg_dst(reg_dst), .unit_id(unit_id), .latency(latency), .reg_wr(reg_wr),
    .ra_data(ra_data), .rb_data(rb_data), .rc_data(rc_data),
    .imme7(imme7), .imme10(imme10), .imme16(imme16), .imme18(imme18),
    .packed_result_1stage(ps[1]), .packed_result_2stage(ps[2]),
    .packed_result_3stage(ps[3]), .packed_result_4stage(ps[4]),
    .packed_result_5stage(ps[5]), .packed_result_6stage(ps[6]),
    .packed_result_7stage(ps[7]),
    .WB_reg_write_addr(wb_addr), .WB_reg_write_data(wb_data),
    .WB_reg_write_en(wb_en)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [142:0] act, input logic [142:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Expected packed word for the inputs currently applied. The unit produces
  // the 128-bit sum (carry dropped) for FX1, and zero for any other unit.
  function automatic logic [142:0] model_word();
    logic [127:0] res;
    res = (unit_id == 3'b000) ? (ra_data + rb_data) : 128'd0;
    return {res, reg_dst, reg_wr, latency, unit_id};
  endfunction

  // ---------------- scoreboard ----------------
  logic [142:0] exp_q[$];

  // Every edge outside reset accepts one entry into the pipe.
  always @(posedge clk) begin
    if (rst) exp_q.push_back(model_word());
  end

  // Monitor: checks every stage and the write port against the queue. With N
  // entries queued, stage k holds the entry issued k-1 edges ago; stages
  // beyond N are still empty. The oldest entry leaves after stage 7.
  always @(negedge clk) begin
    logic [142:0] e;
    int n;
    n = exp_q.size();
    for (int k = 1; k <= 7; k++) begin
      e = (k <= n) ? exp_q[n-k] : '0;
      check($sformatf("stage%0d", k), ps[k], e);
    end
    e = (n >= 7) ? exp_q[0] : '0;
    check("wb_data", {15'd0, wb_data}, {15'd0, e[142:15]});
    check("wb_addr", {136'd0, wb_addr}, {136'd0, e[14:8]});
    check("wb_en", {142'd0, wb_en}, {142'd0, e[7]});
    if (n >= 7) void'(exp_q.pop_front());
  end

  // ---------------- driver tasks ----------------
  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic drive_random();
    full_isntr = $urandom;
    instr_id = 7'($urandom_range(0, 127));
    reg_dst = 7'($urandom_range(0, 127));
    unit_id = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
    latency = 4'($urandom_range(0, 15));
    reg_wr = 1'($urandom_range(0, 1));
    ra_data = rand128();
    rb_data = rand128();
    rc_data = rand128();
    imme7 = 8'($urandom_range(0, 255));
    imme10 = 10'($urandom_range(0, 1023));
    imme16 = 16'($urandom_range(0, 65535));
    imme18 = 18'($urandom_range(0, 262143));
  endtask

  // Moves to a point just after a rising edge, so inputs change away from it.
  task automatic after_edge();
    @(posedge clk);
    #2;
  endtask

  task automatic drive_fx1(input logic [127:0] a, input logic [127:0] b,
                           input logic [6:0] dst, input logic wr, input logic [3:0] lat);
    unit_id = 3'b000;
    ra_data = a;
    rb_data = b;
    reg_dst = dst;
    reg_wr = wr;
    latency = lat;
  endtask

  // ---------------- sequence ----------------
  initial begin
    // 1. Reset held low while the inputs toggle: the pipe must stay empty.
    repeat (4) begin
      after_edge();
      drive_random();
    end
    #1;
    check("reset_stage7", ps[7], '0);
    check("reset_en", {142'd0, wb_en}, 143'd0);

    // 2. A single FX1 add, held on the inputs.
    drive_fx1({16{8'h11}}, {16{8'h22}}, 7'h07, 1'b1, 4'h2);
    rst = 1'b1;
    after_edge();
    check("t2_stage1", ps[1], {{16{8'h33}}, 7'h07, 1'b1, 4'h2, 3'b000});
    repeat (6) after_edge();
    check("t2_wb_addr", {136'd0, wb_addr}, {136'd0, 7'h07});
    check("t2_wb_data", {15'd0, wb_data}, {15'd0, {16{8'h33}}});
    check("t2_wb_en", {142'd0, wb_en}, {142'd0, 1'b1});

    // 3. New operands whose sum carries out of 128 bits; reg_wr is low.
    drive_fx1({16{8'hAA}}, {16{8'hBB}}, 7'h71, 1'b0, 4'h5);
    repeat (7) after_edge();
    check("t3_wb_data", {15'd0, wb_data}, {15'd0, {{15{8'h66}}, 8'h65}});
    check("t3_wb_addr", {136'd0, wb_addr}, {136'd0, 7'h71});
    check("t3_wb_en", {142'd0, wb_en}, 143'd0);

    // 4. A new random instruction every cycle.
    repeat (30) begin
      drive_random();
      after_edge();
    end

    // 5. A non-FX1 unit: the result field is zero and the metadata is kept.
    drive_random();
    unit_id = 3'b001;
    reg_wr = 1'b1;
    reg_dst = 7'h2A;
    latency = 4'h9;
    repeat (7) after_edge();
    check("t5_stage7", ps[7], {128'd0, 7'h2A, 1'b1, 4'h9, 3'b001});

    // 6. Reset asserted between edges flushes the pipe without waiting for a clock edge.
    repeat (3) begin
      drive_random();
      reg_wr = 1'b1;
      after_edge();
    end
    rst = 1'b0;
    exp_q.delete();
    #1;
    for (int k = 1; k <= 7; k++) check($sformatf("t6_flush%0d", k), ps[k], '0);
    check("t6_flush_en", {142'd0, wb_en}, 143'd0);
    after_edge();
    drive_fx1(rand128(), rand128(), 7'h15, 1'b1, 4'h1);
    rst = 1'b1;
    repeat (6) after_edge();
    check("t6_refill_en6", {142'd0, wb_en}, 143'd0);
    after_edge();
    check("t6_refill_en7", {142'd0, wb_en}, {142'd0, 1'b1});

    // More random traffic after the refill.
    repeat (20) begin
      drive_random();
      after_edge();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
